// File: rtl/motor_pkg.sv
// Shared types and helpers for the H-bridge drive sequencer.
// Holds the direction and state encodings plus the saturating duty-step helper.
package motor_pkg;

    typedef enum logic [1:0] {
        DIR_COAST = 2'b00,
        DIR_FWD   = 2'b01,
        DIR_REV   = 2'b10,
        DIR_BRAKE = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RUN       = 3'd1,
        RAMP_DOWN = 3'd2,
        DEAD      = 3'd3,
        BRAKE     = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // Move cur toward tgt by at most step, never passing tgt.
    function automatic int unsigned step_toward(input int unsigned cur,
                                                input int unsigned tgt,
                                                input int unsigned step);
        if (cur < tgt)
            return ((tgt - cur) > step) ? cur + step : tgt;
        else
            return ((cur - tgt) > step) ? cur - step : tgt;
    endfunction

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM timebase: prescaler, period counter (0..2^PWM_BITS-2),
// duty compare and the end-of-period strobe used for duty ramping.
module motor_pwm_gen #(
    parameter int PWM_BITS = 8,
    parameter int PRESC    = 4
) (
    input  logic                Clk,
    input  logic                Rstn,
    input  logic [PWM_BITS-1:0] duty,
    output logic                pwm_on,
    output logic                period_end
);
    localparam int PC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PC_W-1:0]     PC_MAX  = PC_W'(PRESC - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PC_W-1:0]     presc_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;

    assign tick = (presc_cnt == PC_MAX);

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick)
                pwm_cnt <= (pwm_cnt == CNT_MAX) ? '0 : pwm_cnt + 1'b1;
        end
    end

    // Period is one short of 2^PWM_BITS so full-scale duty holds the output high.
    assign period_end = tick & (pwm_cnt == CNT_MAX);
    assign pwm_on     = (pwm_cnt < duty);

endmodule

// File: rtl/motor_drive_seq.sv
// Single-channel H-bridge drive sequencer: ramped PWM, ramp-down plus dead time on
// every direction change, estop. Stall fault detection is built with MOTOR_STALL_DETECT_EN.
module motor_drive_seq #(
    parameter int PWM_BITS       = 8,
    parameter int PRESC          = 4,
    parameter int RAMP_STEP      = 8,
    parameter int DEADTIME_CYC   = 1000,
    parameter int STALL_PERIODS  = 64,
    parameter int STALL_MIN_DUTY = 32
) (
    input  logic                Clk,
    input  logic                Rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_dir,
    input  logic [PWM_BITS-1:0] cmd_duty,
    input  logic                estop,
    input  logic                Evnt,
    input  logic                fault_clr,
    output logic [1:0]          Mt,
    output logic                EN,
    output logic                busy,
    output logic                fault,
    output logic [2:0]          state_o
);
    import motor_pkg::*;

    localparam int DC_W = (DEADTIME_CYC > 1) ? $clog2(DEADTIME_CYC) : 1;
    localparam logic [DC_W-1:0] DEAD_LOAD = DC_W'(DEADTIME_CYC - 1);

    state_t              state, state_nx;
    dir_t                run_dir, run_dir_nx, pending_dir, pending_dir_nx, cmd_d;
    logic [PWM_BITS-1:0] cur_duty, cur_duty_nx, target_duty, target_duty_nx;
    logic [PWM_BITS-1:0] pending_duty, pending_duty_nx;
    logic [DC_W-1:0]     dead_cnt, dead_cnt_nx;
    logic [1:0]          mt_nx;
    logic                en_nx, accept, pwm_on, period_end, stall_hit;

    motor_pwm_gen #(.PWM_BITS(PWM_BITS), .PRESC(PRESC)) u_pwm (
        .Clk        (Clk),
        .Rstn       (Rstn),
        .duty       (cur_duty),
        .pwm_on     (pwm_on),
        .period_end (period_end)
    );

    // cmd handshake: a command transfers on a clock edge where cmd_valid and cmd_ready
    // are both high; cmd_ready never depends on cmd_valid and the requester holds
    // cmd_valid/cmd_dir/cmd_duty stable until that edge.
    assign cmd_d     = dir_t'(cmd_dir);
    assign cmd_ready = ((state == IDLE) || (state == RUN) || (state == BRAKE)) && !estop;
    assign accept    = cmd_valid && cmd_ready;
    assign busy      = (state == RAMP_DOWN) || (state == DEAD);
    assign state_o   = state;

    always_comb begin
        state_nx        = state;
        run_dir_nx      = run_dir;
        pending_dir_nx  = pending_dir;
        pending_duty_nx = pending_duty;
        cur_duty_nx     = cur_duty;
        target_duty_nx  = target_duty;
        dead_cnt_nx     = dead_cnt;
        mt_nx           = 2'b00;
        en_nx           = 1'b0;
        if (accept) begin
            pending_dir_nx  = cmd_d;
            pending_duty_nx = cmd_duty;
        end
        case (state)
            IDLE: if (accept) begin
                if (cmd_d == DIR_FWD || cmd_d == DIR_REV) begin
                    state_nx       = RUN;
                    run_dir_nx     = cmd_d;
                    target_duty_nx = cmd_duty;
                    cur_duty_nx    = '0;
                end else if (cmd_d == DIR_BRAKE) begin
                    state_nx = BRAKE;
                end
            end
            RUN: begin
                if (period_end)
                    cur_duty_nx = PWM_BITS'(step_toward(32'(cur_duty), 32'(target_duty), RAMP_STEP));
                if (accept) begin
                    if (cmd_d == run_dir) begin
                        target_duty_nx = cmd_duty;
                    end else begin
                        target_duty_nx = '0;
                        state_nx       = RAMP_DOWN;
                    end
                end
            end
            RAMP_DOWN: if (period_end) begin
                if (cur_duty == '0) begin
                    state_nx    = DEAD;
                    dead_cnt_nx = DEAD_LOAD;
                end else begin
                    cur_duty_nx = PWM_BITS'(step_toward(32'(cur_duty), 32'(target_duty), RAMP_STEP));
                end
            end
            DEAD: begin
                if (dead_cnt == '0) begin
                    case (pending_dir)
                        DIR_FWD, DIR_REV: begin
                            state_nx       = RUN;
                            run_dir_nx     = pending_dir;
                            target_duty_nx = pending_duty;
                            cur_duty_nx    = '0;
                        end
                        DIR_BRAKE: state_nx = BRAKE;
                        default:   state_nx = IDLE;
                    endcase
                end else begin
                    dead_cnt_nx = dead_cnt - 1'b1;
                end
            end
            BRAKE: if (accept && cmd_d != DIR_BRAKE) begin
                state_nx    = DEAD;
                dead_cnt_nx = DEAD_LOAD;
            end
            FAULT: begin
`ifdef MOTOR_STALL_DETECT_EN
                if (fault_clr) begin
                    state_nx        = DEAD;
                    dead_cnt_nx     = DEAD_LOAD;
                    pending_dir_nx  = DIR_COAST;
                    pending_duty_nx = '0;
                end
`endif
            end
            default: state_nx = IDLE;
        endcase
        // estop outranks everything except a latched fault.
        if (state != FAULT) begin
            if (estop) begin
                state_nx        = DEAD;
                dead_cnt_nx     = DEAD_LOAD;
                cur_duty_nx     = '0;
                target_duty_nx  = '0;
                pending_dir_nx  = DIR_COAST;
                pending_duty_nx = '0;
            end else if (stall_hit) begin
                state_nx       = FAULT;
                cur_duty_nx    = '0;
                target_duty_nx = '0;
            end
        end
        // Pins follow the state being entered so Mt and EN never disagree for a cycle.
        case (state_nx)
            RUN: begin
                mt_nx = run_dir_nx;
                en_nx = pwm_on;
            end
            RAMP_DOWN: mt_nx = run_dir_nx;
            BRAKE: begin
                mt_nx = DIR_BRAKE;
                en_nx = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            state        <= IDLE;
            run_dir      <= DIR_COAST;
            pending_dir  <= DIR_COAST;
            pending_duty <= '0;
            cur_duty     <= '0;
            target_duty  <= '0;
            dead_cnt     <= '0;
            Mt           <= 2'b00;
            EN           <= 1'b0;
        end else begin
            state        <= state_nx;
            run_dir      <= run_dir_nx;
            pending_dir  <= pending_dir_nx;
            pending_duty <= pending_duty_nx;
            cur_duty     <= cur_duty_nx;
            target_duty  <= target_duty_nx;
            dead_cnt     <= dead_cnt_nx;
            Mt           <= mt_nx;
            EN           <= en_nx;
        end
    end

`ifdef MOTOR_STALL_DETECT_EN
    localparam int SC_W = $clog2(STALL_PERIODS + 1);
    logic [2:0]      evnt_sync;
    logic            evnt_edge;
    logic [SC_W-1:0] stall_cnt;

    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            evnt_sync <= 3'b000;
            stall_cnt <= '0;
        end else begin
            evnt_sync <= {evnt_sync[1:0], Evnt};
            if (evnt_edge || state != RUN || cur_duty < PWM_BITS'(STALL_MIN_DUTY))
                stall_cnt <= '0;
            else if (period_end && !stall_hit)
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign evnt_edge = evnt_sync[2] ^ evnt_sync[1];
    assign stall_hit = (stall_cnt == SC_W'(STALL_PERIODS));
    assign fault     = (state == FAULT);
`else
    logic unused_stall_in;
    assign unused_stall_in = Evnt ^ fault_clr ^ (STALL_PERIODS == 0) ^ (STALL_MIN_DUTY == 0);
    assign stall_hit = 1'b0;
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_motor_drive_seq.sv
// Bench for motor_drive_seq: random commands against a period-level duty/timing model.
// Exercises the stall path too when built with MOTOR_STALL_DETECT_EN.
module tb_motor_drive_seq;

    localparam int PER = 255;
    localparam int STEP = 64;
    localparam int DEAD_CYC = 16;
    localparam int D_COAST = 0, D_FWD = 1, D_REV = 2, D_BRAKE = 3;
    localparam int S_IDLE = 0, S_RUN = 1, S_RAMP = 2, S_DEAD = 3, S_BRAKE = 4, S_FAULT = 5;

    logic       Clk = 1'b0;
    logic       Rstn, cmd_valid, cmd_ready, estop, Evnt, fault_clr;
    logic [1:0] cmd_dir, Mt;
    logic [7:0] cmd_duty;
    logic       EN, busy, fault;
    logic [2:0] state_o;

    int k;            // index of the most recent rising edge since reset release
    int total = 0;
    int bad = 0;
    int fault_seen = 0;

    motor_drive_seq #(
        .PWM_BITS(8), .PRESC(1), .RAMP_STEP(STEP), .DEADTIME_CYC(DEAD_CYC),
        .STALL_PERIODS(4), .STALL_MIN_DUTY(32)
    ) dut (
        .Clk(Clk), .Rstn(Rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .estop(estop), .Evnt(Evnt),
        .fault_clr(fault_clr), .Mt(Mt), .EN(EN), .busy(busy), .fault(fault),
        .state_o(state_o)
    );

    always #5 Clk = ~Clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        k++;
    endtask

    task automatic advance(input int j);
        while (k < j) step();
    endtask

    // Reference rules: saturating duty step, and the edge index of each period end.
    function automatic int ramp(input int cur, input int tgt);
        if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
        return (cur - STEP < tgt) ? tgt : cur - STEP;
    endfunction

    function automatic int next_pe(input int j);
        int n;
        n = j + 1;
        return n + ((PER - 1) - (n % PER));
    endfunction

    // Edge at which ramp-down from duty cur (accepted at edge a) reaches dead time.
    function automatic int rampdown_end(input int a, input int cur);
        int j, d;
        j = a;
        d = cur;
        for (int i = 0; i < 16; i++) begin
            j = next_pe(j);
            if (d == 0) break;
            d = ramp(d, 0);
        end
        return j;
    endfunction

    task automatic send_cmd(input int dir, input int duty, output int acc);
        cmd_dir = dir[1:0];
        cmd_duty = duty[7:0];
        cmd_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 4000; i++) begin
            if (cmd_ready === 1'b1) begin
                step();
                acc = k;
                break;
            end
            step();
        end
        cmd_valid = 1'b0;
        if (acc < 0) begin
            check("cmd_accept_timeout", 0, 1);
            acc = k;
        end
    endtask

    // RUN entered (or target changed) at edge a with duty start: EN high count per full period.
    task automatic check_ramp(input int a, input int start, input int tgt, input int mt);
        int s, d, cnt, mt_bad;
        d = start;
        s = (a / PER + 1) * PER;
        if (s - 1 > a) d = ramp(d, tgt);
        for (int p = 0; p < 8; p++) begin
            advance(s - 1);
            cnt = 0;
            mt_bad = 0;
            for (int i = 0; i < PER; i++) begin
                step();
                cnt += int'(EN);
                if (Mt !== mt[1:0]) mt_bad++;
            end
            check("en_per_period", cnt, d);
            check("mt_during_run", mt_bad, 0);
            if (d == tgt) break;
            d = ramp(d, tgt);
            s += PER;
        end
    endtask

    // Current sample is the first of the dead time; then the follow-on state and pins.
    task automatic check_dead(input int st, input int mt, input int en);
        int bad_cnt;
        bad_cnt = 0;
        for (int i = 0; i < DEAD_CYC; i++) begin
            if (i > 0) step();
            if (Mt !== 2'b00 || EN !== 1'b0 || state_o !== 3'(S_DEAD) || busy !== 1'b1) bad_cnt++;
        end
        check("dead_window", bad_cnt, 0);
        step();
        check("after_dead_state", state_o, st);
        check("after_dead_mt", Mt, mt);
        check("after_dead_en", EN, en);
    endtask

    task automatic wait_rampdown(input int d0, input int mt);
        int mt_bad;
        mt_bad = 0;
        while (k < d0) begin
            if (Mt !== mt[1:0] || busy !== 1'b1) mt_bad++;
            step();
        end
        check("rampdown_hold", mt_bad, 0);
    endtask

    task automatic estop_with_cmd();
        estop = 1'b1;
        cmd_valid = 1'b1;
        cmd_dir = 2'b01;
        cmd_duty = 8'd50;
        #1;
        check("ready_in_estop", cmd_ready, 0);
        step();
        estop = 1'b0;
        cmd_valid = 1'b0;
        check_dead(S_IDLE, 0, 0);
        repeat (20) step();
        check("estop_cmd_dropped", state_o, S_IDLE);
    endtask

    task automatic run_and_coast(input int dir, input int duty);
        int a, d0;
        send_cmd(dir, duty, a);
        check("run_mt", Mt, dir);
        check_ramp(a, 0, duty, dir);
        send_cmd(D_COAST, 0, a);
        check("coast_ready", cmd_ready, 0);
        d0 = rampdown_end(a, duty);
        wait_rampdown(d0, dir);
        check_dead(S_IDLE, 0, 0);
    endtask

`ifndef MOTOR_STALL_DETECT_EN
    always @(negedge Clk) if (Rstn === 1'b1 && fault !== 1'b0) fault_seen = 1;
`endif

    initial begin
        int a, d0, dir, duty;
        Rstn = 1'b0;
        cmd_valid = 1'b0;
        cmd_dir = 2'b00;
        cmd_duty = 8'd0;
        estop = 1'b0;
        Evnt = 1'b0;
        fault_clr = 1'b0;
        repeat (3) @(negedge Clk);
        Rstn = 1'b1;
        k = -1;
        check("rst_mt", Mt, 0);
        check("rst_en", EN, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_fault", fault, 0);
        check("rst_state", state_o, S_IDLE);
        check("rst_busy", busy, 0);

        // fwd 128 from IDLE
        send_cmd(D_FWD, 128, a);
        check("fwd_mt", Mt, D_FWD);
        check("fwd_state", state_o, S_RUN);
        check_ramp(a, 0, 128, D_FWD);

        // reversal to rev 200
        send_cmd(D_REV, 200, a);
        check("rev_ready", cmd_ready, 0);
        check("rev_busy", busy, 1);
        check("rev_state", state_o, S_RAMP);
        d0 = rampdown_end(a, 128);
        wait_rampdown(d0, D_FWD);
        check_dead(S_RUN, D_REV, 0);
        check("rev_ready_back", cmd_ready, 1);
        check_ramp(k, 0, 200, D_REV);

        estop_with_cmd();

        // estop at random points during ramp-up
        for (int r = 0; r < 3; r++) begin
            dir = $urandom_range(1, 2);
            duty = $urandom_range(100, 255);
            send_cmd(dir, duty, a);
            check("estop_run_mt", Mt, dir);
            repeat ($urandom_range(1, 2 * PER)) step();
            estop_with_cmd();
        end

        for (int r = 0; r < 3; r++)
            run_and_coast($urandom_range(1, 2), $urandom_range(1, 255));

        // duty 0 then 255, then brake
        send_cmd(D_FWD, 0, a);
        check("zero_mt", Mt, D_FWD);
        check_ramp(a, 0, 0, D_FWD);
        send_cmd(D_FWD, 255, a);
        check_ramp(a, 0, 255, D_FWD);
        send_cmd(D_BRAKE, 0, a);
        d0 = rampdown_end(a, 255);
        wait_rampdown(d0, D_FWD);
        check_dead(S_BRAKE, 3, 1);
        send_cmd(D_BRAKE, 0, a);
        repeat (5) step();
        check("brake_stay_state", state_o, S_BRAKE);
        check("brake_stay_en", EN, 1);
        send_cmd(D_COAST, 0, a);
        check_dead(S_IDLE, 0, 0);

`ifdef MOTOR_STALL_DETECT_EN
        begin
            int p5, early;
            send_cmd(D_FWD, 128, a);
            p5 = next_pe(a) + 4 * PER;
            early = 0;
            while (k < p5) begin
                if (fault !== 1'b0) early++;
                step();
            end
            if (fault !== 1'b0) early++;
            check("stall_early", early, 0);
            step();
            check("stall_fault", fault, 1);
            check("stall_mt", Mt, 0);
            check("stall_en", EN, 0);
            check("stall_state", state_o, S_FAULT);
            check("stall_ready", cmd_ready, 0);
            fault_clr = 1'b1;
            step();
            fault_clr = 1'b0;
            check_dead(S_IDLE, 0, 0);
            check("clr_fault", fault, 0);
            send_cmd(D_FWD, 128, a);
            early = 0;
            for (int p = 0; p < 8; p++) begin
                for (int i = 0; i < PER; i++) begin
                    step();
                    if (fault !== 1'b0) early++;
                end
                Evnt = ~Evnt;
            end
            check("toggle_no_fault", early, 0);
        end
`else
        check("fault_never_set", fault_seen, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_drive_seq.md
Name: motor_drive_seq

Overview:
- Single-channel H-bridge drive sequencer for the chassis motor outputs (Mt[1:0] direction pair, EN PWM enable).
- Takes direction/duty commands from the CPU peripheral register block over a valid/ready handshake.
- Generates glitch-free PWM, ramps duty, and enforces ramp-down plus a dead time on every direction change.
- Instantiated twice in TwoWhellPlatform, once for channel a and once for channel b.

Parameters:
- PWM_BITS, 8, duty width; PWM period is 2^PWM_BITS-1 ticks.
- PRESC, 4, clocks per PWM tick (>=1).
- RAMP_STEP, 8, maximum duty change per PWM period end.
- DEADTIME_CYC, 1000, clocks with Mt=00/EN=0 between drive states.
- STALL_PERIODS, 64, PWM periods without an encoder edge before fault (optional feature only).
- STALL_MIN_DUTY, 32, minimum cur_duty for stall checking (optional feature only).

Ports:
- Clk  in  1  system clock.
- Rstn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted.
- cmd_dir  in  2  00 coast, 01 fwd, 10 rev, 11 brake.
- cmd_duty  in  PWM_BITS  target duty.
- estop  in  1  synchronous emergency stop, level.
- Evnt  in  1  encoder pulse, asynchronous.
- fault_clr  in  1  single-cycle fault clear pulse.
- Mt  out  2  bridge direction pins, registered.
- EN  out  1  PWM enable, registered.
- busy  out  1  state is RAMP_DOWN or DEAD.
- fault  out  1  stall fault flag.
- state_o  out  3  current state encoding.

Behaviour:
- Reset (async, Rstn low) sets: Mt=00, EN=0, cur_duty=0, state=IDLE, fault=0, pending cleared, pwm_cnt=0. cmd_ready reads 1 after reset.
- PWM:
  - tick every PRESC clocks; pwm_cnt runs 0..2^PWM_BITS-2 and wraps, free-running.
  - period_end = tick & (pwm_cnt==max).
  - EN <= (state==RUN) & (pwm_cnt < cur_duty). Duty 0 gives EN never high; duty 255 gives EN constant high.
  - In BRAKE, EN=1.
- Ramp: cur_duty moves toward target_duty by at most RAMP_STEP, only at period_end. Arithmetic saturates: no overshoot, no wrap.
- Handshake:
  - Accept on cmd_valid & cmd_ready.
  - cmd_ready = (state in IDLE, RUN, BRAKE) & !estop.
  - An accepted command is latched into pending_dir/pending_duty.
- States and transitions:
  - IDLE: Mt=00. On fwd/rev, next cycle Mt=dir, state RUN, target=duty, ramping from 0. On brake, go to BRAKE (Mt=11). On coast, stay in IDLE.
  - RUN: a command with the same dir updates target only. A different dir (coast, brake or reversal) sets target=0 and goes to RAMP_DOWN.
  - RAMP_DOWN: when cur_duty==0 at period_end, set Mt=00, load the dead-time counter, go to DEAD.
  - DEAD: Mt=00 for exactly DEADTIME_CYC clocks. Then apply pending: coast goes to IDLE; fwd/rev goes to RUN (Mt=dir, ramp from 0); brake goes to BRAKE.
  - BRAKE: a brake command stays in BRAKE. Any other command goes to DEAD, then pending is applied.
  - FAULT: Mt=00, EN=0, fault=1. fault_clr goes to DEAD with pending=coast.
- estop has highest priority in any state except FAULT:
  - next cycle cur_duty=0, EN=0, Mt=00, pending=coast, state DEAD.
  - If cmd_valid arrives in the same cycle, it is not accepted.
- A new command is never accepted mid-sequence; the requester holds cmd_valid.
- Counter widths are $clog2 of their maxima.

Optional Feature:
- Macro MOTOR_STALL_DETECT_EN.
- Defined:
  - Evnt passes a 2-FF synchronizer and both-edge detect.
  - stall_cnt clears on an edge or when not (RUN & cur_duty>=STALL_MIN_DUTY); otherwise it increments per period_end.
  - Reaching STALL_PERIODS forces FAULT next cycle: EN=0, Mt=00, cur_duty=0.
  - fault_clr behaves as specified above.
- Undefined: Evnt is ignored, fault is tied to 0, FAULT is unreachable, and fault_clr is ignored.

Decomposition:
- Package motor_pkg:
  - typedef enum logic[1:0] dir_t: DIR_COAST, DIR_FWD, DIR_REV, DIR_BRAKE.
  - typedef enum logic[2:0] state_t: IDLE, RUN, RAMP_DOWN, DEAD, BRAKE, FAULT.
- Sub-module motor_pwm_gen: prescaler, pwm_cnt, compare and period_end strobe. This is the natural sub-module.

Test Plan (bench params PRESC=1, RAMP_STEP=64, DEADTIME_CYC=16, STALL_PERIODS=4):
- Reset release -> Mt=00, EN=0, cmd_ready=1, fault=0, state_o=IDLE.
- IDLE, cmd fwd duty 128 -> Mt=01 next cycle; cur_duty 64 after 1st period_end, 128 after 2nd; EN then high 128 of 255 ticks per period.
- RUN fwd 128, cmd rev 200 -> cmd_ready=0, busy=1; duty steps 64 then 0; Mt=00 exactly 16 clocks; Mt=10; duty 64,128,192,200; cmd_ready=1.
- estop with cmd_valid in the same cycle during the ramp up -> command not accepted; EN=0, Mt=00 next cycle; DEAD 16 clocks; IDLE.
- Duty 0 fwd -> EN never high with Mt=01; duty 255 -> EN constant 1 once ramped. Brake cmd -> Mt=11, EN=1.
- MOTOR_STALL_DETECT_EN defined, duty 128, Evnt held low -> fault=1 after 4th qualifying period_end, outputs Mt=00, EN=0; fault_clr -> DEAD 16 clocks -> IDLE. Evnt toggling every period -> no fault.
